alu_exec_sequencer: RTL and testbench

Step sequencer that drives the datapath for one ALU-class instruction at a time. It latches the instruction word on `start` and walks the bus-transfer steps: load Y, present the second operand with the ALU opcode, strobe Z, then write Z back to the register file or to HI/LO. It sits directly upstream of the ALU and owns `opcode`, `y_in` and `z_in` plus every bus/register strobe those steps need. Non-ALU opcodes are rejected.

---
 rtl/alu_exec_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_exec_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_sequencer.sv
// alu_exec_sequencer: step sequencer for one ALU-class instruction.
// Latches the instruction on start, then walks T3 (load Y), T4 (operand and
// opcode, strobe Z), T5 (Z low write-back) and T6 (Z high to HI, mul/div only).
// Unsupported opcodes take a single ERR cycle that flags illegal.
module alu_exec_sequencer #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [4:0]  opcode,
  output logic [3:0]  reg_sel,
  output logic        reg_out,
  output logic        reg_in,
  output logic        c_out,
  output logic        y_in,
  output logic        z_in,
  output logic        zlo_out,
  output logic        zhi_out,
  output logic        lo_in,
  output logic        hi_in
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [4:0] OP_MUL = 5'b01110;

  typedef enum logic [2:0] {S_IDLE, S_T3, S_T4, S_T5, S_T6, S_ERR} state_t;
  typedef enum logic [2:0] {C_R, C_I, C_M, C_U, C_BAD} cls_t;

  // Instruction class from the 5-bit opcode.
  function automatic cls_t classify(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd10)       return C_R;
    else if (op >= 5'd11 && op <= 5'd13) return C_I;
    else if (op == 5'd14 || op == 5'd15) return C_M;
    else if (op == 5'd16 || op == 5'd17) return C_U;
    else                                 return C_BAD;
  endfunction

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_ir;
  logic [CW-1:0]   r_wait;

  cls_t            w_cls;
  cls_t            w_in_cls;
  logic [4:0]      w_op;
  logic [3:0]      w_ra;
  logic [3:0]      w_rb;
  logic [3:0]      w_rc;
  logic [CW-1:0]   w_wait_load;
  logic            w_last_wait;
  logic            w_unused_ir;

  assign w_op     = r_ir[31:27];
  assign w_ra     = r_ir[26:23];
  assign w_rb     = r_ir[22:19];
  assign w_rc     = r_ir[18:15];
  assign w_cls    = classify(w_op);
  assign w_in_cls = classify(ir[31:27]);

  // The immediate field feeds the constant path outside this block.
  assign w_unused_ir = ^r_ir[14:0];

  assign w_wait_load = (w_op == OP_MUL) ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
  // Non-M instructions spend exactly one cycle in T4.
  assign w_last_wait = (w_cls != C_M) || (r_wait == CW'(1));

  // State register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Instruction latch: captured only when a start is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (!clear)                          r_ir <= '0;
    else if (r_state == S_IDLE && start) r_ir <= ir;
  end

  // Wait down-counter: loads entering T4, counts while holding there.
  always_ff @(posedge clk) begin
    if (!clear)                                 r_wait <= '0;
    else if (r_state == S_T3 && w_next == S_T4) r_wait <= w_wait_load;
    else if (r_state == S_T4 && r_wait != '0)   r_wait <= r_wait - 1'b1;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: a default on every comb output before the case prevents latches.
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (w_in_cls)
            C_BAD:   w_next = S_ERR;
            C_U:     w_next = S_T4;
            default: w_next = S_T3;
          endcase
        end
      end
      S_T3:    w_next = S_T4;
      S_T4:    w_next = w_last_wait ? S_T5 : S_T4;
      S_T5:    w_next = (w_cls == C_M) ? S_T6 : S_IDLE;
      S_T6:    w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from registered state and latched instruction only.
  always_comb begin
    busy    = (r_state != S_IDLE);
    opcode  = busy ? w_op : 5'd0;
    done    = 1'b0;
    illegal = 1'b0;
    reg_sel = 4'd0;
    reg_out = 1'b0;
    reg_in  = 1'b0;
    c_out   = 1'b0;
    y_in    = 1'b0;
    z_in    = 1'b0;
    zlo_out = 1'b0;
    zhi_out = 1'b0;
    lo_in   = 1'b0;
    hi_in   = 1'b0;
    case (r_state)
      S_T3: begin
        reg_sel = (w_cls == C_M) ? w_ra : w_rb;
        reg_out = 1'b1;
        y_in    = 1'b1;
      end
      S_T4: begin
        if (w_cls == C_I) begin
          c_out = 1'b1;
        end else begin
          reg_sel = (w_cls == C_R) ? w_rc : w_rb;
          reg_out = 1'b1;
        end
        z_in = w_last_wait;
      end
      S_T5: begin
        zlo_out = 1'b1;
        if (w_cls == C_M) begin
          lo_in = 1'b1;
        end else begin
          reg_sel = w_ra;
          reg_in  = 1'b1;
          done    = 1'b1;
        end
      end
      S_T6: begin
        zhi_out = 1'b1;
        hi_in   = 1'b1;
        done    = 1'b1;
      end
      S_ERR: begin
        done    = 1'b1;
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Testbench for alu_exec_sequencer: a driver issues directed and random
// instructions and pushes the expected per-cycle outputs into a scoreboard;
// a monitor pops and compares every busy cycle and checks idle cycles are all zero.
module tb_alu_exec_sequencer;

  localparam int MULC = 2;
  localparam int DIVC = 4;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] ir;
  logic        busy, done, illegal;
  logic [4:0]  opcode;
  logic [3:0]  reg_sel;
  logic        reg_out, reg_in, c_out, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       illegal;
    logic [4:0] opcode;
    logic [3:0] reg_sel;
    logic       reg_out;
    logic       reg_in;
    logic       c_out;
    logic       y_in;
    logic       z_in;
    logic       zlo_out;
    logic       zhi_out;
    logic       lo_in;
    logic       hi_in;
  } obs_t;

  obs_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_exec_sequencer #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .clear(clear), .start(start), .ir(ir),
    .busy(busy), .done(done), .illegal(illegal), .opcode(opcode),
    .reg_sel(reg_sel), .reg_out(reg_out), .reg_in(reg_in), .c_out(c_out),
    .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out), .zhi_out(zhi_out),
    .lo_in(lo_in), .hi_in(hi_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    logic [31:0] r;
    r = $urandom();
    return {op, ra, rb, rc, r[14:0]};
  endfunction

  // Reference model: expected output sequence for one instruction, from the
  // class rules (operand source, Z hold length, write-back target).
  task automatic model_push(input logic [31:0] w, output int n);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    obs_t       e, base;
    int         hold;
    op = w[31:27]; ra = w[26:23]; rb = w[22:19]; rc = w[18:15];
    base = '0;
    base.busy = 1'b1;
    base.opcode = op;
    n = 0;
    if (op >= 3 && op <= 13) begin
      // R and I: load rb into Y, combine with rc or the constant, write ra.
      e = base; e.reg_sel = rb; e.reg_out = 1; e.y_in = 1; sb.push_back(e);
      e = base; e.z_in = 1;
      if (op <= 10) begin e.reg_sel = rc; e.reg_out = 1; end
      else e.c_out = 1;
      sb.push_back(e);
      e = base; e.zlo_out = 1; e.reg_sel = ra; e.reg_in = 1; e.done = 1; sb.push_back(e);
      n = 3;
    end else if (op == 14 || op == 15) begin
      hold = (op == 14) ? MULC : DIVC;
      e = base; e.reg_sel = ra; e.reg_out = 1; e.y_in = 1; sb.push_back(e);
      for (int k = 0; k < hold; k++) begin
        e = base; e.reg_sel = rb; e.reg_out = 1; e.z_in = (k == hold - 1); sb.push_back(e);
      end
      e = base; e.zlo_out = 1; e.lo_in = 1; sb.push_back(e);
      e = base; e.zhi_out = 1; e.hi_in = 1; e.done = 1; sb.push_back(e);
      n = 3 + hold;
    end else if (op == 16 || op == 17) begin
      e = base; e.reg_sel = rb; e.reg_out = 1; e.z_in = 1; sb.push_back(e);
      e = base; e.zlo_out = 1; e.reg_sel = ra; e.reg_in = 1; e.done = 1; sb.push_back(e);
      n = 2;
    end else begin
      e = base; e.done = 1; e.illegal = 1; sb.push_back(e);
      n = 1;
    end
  endtask

  // Issue one instruction; scrambles ir while busy and optionally pulses start.
  task automatic issue(input logic [31:0] w, input bit poke);
    int n;
    model_push(w, n);
    ir = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ir = $urandom();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      ir = $urandom();
      start = poke && (k == 1) && (n >= 2);
    end
    start = 1'b0;
  endtask

  // Start a mul, then clear during its second wait cycle with start raised.
  task automatic abort_mul();
    int n;
    model_push(mk(5'b01110, 4'd1, 4'd2, 4'd0), n);
    ir = sb[0].opcode == 5'b01110 ? {5'b01110, 4'd1, 4'd2, 19'd0} : 32'd0;
    start = 1'b1;
    @(posedge clk); #1;          // edge 0 accepted, T3 follows
    start = 1'b0;
    @(posedge clk); #1;          // first wait cycle
    @(posedge clk); #1;          // second wait cycle
    clear = 1'b0; start = 1'b1; ir = 32'h1891_8000;
    @(posedge clk); #1;          // reset edge wins over start
    clear = 1'b1; start = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every busy cycle against the scoreboard; idle must be all zero.
  initial begin
    obs_t act, exp;
    @(posedge clk);
    forever begin
      @(negedge clk);
      act = {busy, done, illegal, opcode, reg_sel, reg_out, reg_in, c_out,
             y_in, z_in, zlo_out, zhi_out, lo_in, hi_in};
      if (busy === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_busy", 32'(act), 32'(obs_t'('0)));
        end else begin
          exp = sb.pop_front();
          check("busy_cycle", 32'(act), 32'(exp));
        end
      end else begin
        check("idle_zero", 32'(act), 32'd0);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  // Driver.
  initial begin
    logic [31:0] r;
    logic [4:0]  op;
    clear = 1'b0; start = 1'b0; ir = 32'd0;
    repeat (3) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1;

    issue(32'h1891_8000, 0);                     // add r1,r2,r3
    issue(mk(5'b01011, 4'd4, 4'd5, 4'd9), 0);    // addi r4,r5,imm
    issue(mk(5'b01111, 4'd2, 4'd3, 4'd0), 0);    // div
    issue(mk(5'b10000, 4'd6, 4'd7, 4'd0), 0);    // neg r6,r7
    issue(mk(5'b10010, 4'd1, 4'd1, 4'd1), 0);    // illegal
    issue(mk(5'b11111, 4'd15, 4'd15, 4'd15), 0); // illegal
    issue(mk(5'b00010, 4'd3, 4'd4, 4'd5), 0);    // just below R range
    issue(mk(5'b01010, 4'd8, 4'd9, 4'd10), 0);   // last R
    issue(mk(5'b01101, 4'd11, 4'd12, 4'd13), 0); // last I
    issue(mk(5'b10001, 4'd14, 4'd0, 4'd1), 0);   // last U
    issue(mk(5'b01110, 4'd5, 4'd6, 4'd7), 0);    // mul

    issue(32'h1891_8000, 1);                     // start while busy ignored
    repeat (2) @(posedge clk);
    #1;
    issue(mk(5'b01111, 4'd3, 4'd1, 4'd2), 1);
    repeat (2) @(posedge clk);
    #1;

    abort_mul();

    for (int i = 0; i < 80; i++) begin
      r  = $urandom();
      op = 5'($urandom_range(0, 31));
      issue({op, r[26:0]}, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
